// File: rtl/led_sequencer.sv
// Stepping LED pattern generator: a programmable period counter advances one of
// four patterns (rotate left/right, bounce, binary count) on each step.
module led_sequencer #(
  parameter int               N_LED   = 4,
  parameter int               DIV_W   = 32,
  parameter logic [DIV_W-1:0] DIV_RST = 24_999_999
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIV_LD,
  input  logic [DIV_W-1:0] DIV,
  output logic [N_LED-1:0] LED,
  output logic             TICK
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  localparam logic [N_LED-1:0] LED_INIT = {{(N_LED-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             tick_q, tick_d;

  logic [N_LED-1:0] led_rol, led_ror, led_shl, led_shr, led_inc;

  assign led_rol = {led_q[N_LED-2:0], led_q[N_LED-1]};
  assign led_ror = {led_q[0], led_q[N_LED-1:1]};
  assign led_shl = {led_q[N_LED-2:0], 1'b0};
  assign led_shr = {1'b0, led_q[N_LED-1:1]};
  assign led_inc = led_q + 1'b1;

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    tick_d = 1'b0;

    if (DIV_LD) begin
      // A new period restarts the count and suppresses any step this cycle.
      per_d = DIV;
      cnt_d = '0;
    end else if (EN) begin
      // >= lets a shortened period take effect immediately.
      if (cnt_q >= per_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (MODE != mode_q) begin
          mode_d = mode_e'(MODE);
          led_d  = LED_INIT;
          dir_d  = 1'b0;
        end else begin
          case (mode_q)
            MODE_ROL: led_d = led_rol;
            MODE_ROR: led_d = led_ror;
            MODE_BOUNCE: begin
              if (!dir_q) begin
                if (led_q[N_LED-1]) begin
                  led_d = led_shr;
                  dir_d = 1'b1;
                end else begin
                  led_d = led_shl;
                end
              end else begin
                if (led_q[0]) begin
                  led_d = led_shl;
                  dir_d = 1'b0;
                end else begin
                  led_d = led_shr;
                end
              end
            end
            MODE_COUNT: led_d = led_inc;
          endcase
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      per_q  <= DIV_RST;
      mode_q <= MODE_ROL;
      dir_q  <= 1'b0;
      led_q  <= LED_INIT;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign LED  = led_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked against a step-index model.
module tb_led_sequencer;

  localparam int         N     = 4;
  localparam int         DW    = 8;
  localparam logic [7:0] DRST  = 8'd5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          EN = 1'b0;
  logic [1:0]    MODE = 2'b00;
  logic          DIV_LD = 1'b0;
  logic [DW-1:0] DIV = '0;
  logic [N-1:0]  LED;
  logic          TICK;

  int vectors = 0;
  int miscompares = 0;

  led_sequencer #(.N_LED(N), .DIV_W(DW), .DIV_RST(DRST)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIV_LD(DIV_LD),
    .DIV(DIV), .LED(LED), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  // Model: the pattern is a function of the active mode and the number of
  // steps taken since that mode was entered.
  int   m_cnt = 0, m_per = 0, m_mode = 0, m_idx = 0;
  logic m_tick = 1'b0;
  logic m_valid = 1'b0;

  function automatic logic [N-1:0] model_led(input int mode, input int idx);
    int p;
    case (mode)
      0: p = idx % N;
      1: p = (N - (idx % N)) % N;
      2: begin
        p = idx % (2*N - 2);
        if (p >= N) p = 2*N - 2 - p;
      end
      default: return N'((idx + 1) % (1 << N));
    endcase
    return N'(1 << p);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_cnt <= 0; m_per <= int'(DRST); m_mode <= 0; m_idx <= 0;
      m_tick <= 1'b0; m_valid <= 1'b1;
    end else if (DIV_LD) begin
      m_per <= int'(DIV); m_cnt <= 0; m_tick <= 1'b0;
    end else if (EN) begin
      if (m_cnt >= m_per) begin
        m_cnt <= 0; m_tick <= 1'b1;
        if (int'(MODE) != m_mode) begin
          m_mode <= int'(MODE); m_idx <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end else begin
        m_cnt <= m_cnt + 1; m_tick <= 1'b0;
      end
    end else begin
      m_tick <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      vectors++;
      if (LED !== model_led(m_mode, m_idx) || TICK !== m_tick) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: LED=%b TICK=%b, required LED=%b TICK=%b",
                 $time, LED, TICK, model_led(m_mode, m_idx), m_tick);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end else begin
      $display("chk %s: got %0h ok", name, got);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; DIV_LD = 1'b0;
    cyc(); cyc();
    RST = 1'b0;
  endtask

  task automatic load_and_run(input logic [DW-1:0] d, input logic [1:0] m);
    DIV_LD = 1'b1; DIV = d; EN = 1'b1; MODE = m;
    cyc();
    check("load_no_tick", 32'(TICK), 0);
    DIV_LD = 1'b0;
  endtask

  logic [N-1:0] exp_rol[4]    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] exp_bounce[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    // Reset state
    do_reset();
    check("rst_led", 32'(LED), 32'h1);
    check("rst_tick", 32'(TICK), 0);

    // Period 3, rotate left: a step every 4th enabled cycle
    load_and_run(8'd3, 2'b00);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check("rol_tick", 32'(TICK), (k % 4 == 0) ? 32'h1 : 32'h0);
      if (k % 4 == 0) check("rol_led", 32'(LED), 32'(exp_rol[k/4 - 1]));
    end

    // Bounce at period 0: first step enters the mode, tick every cycle
    do_reset();
    load_and_run(8'd0, 2'b10);
    for (int s = 0; s < 8; s++) begin
      cyc();
      check("bounce_led", 32'(LED), 32'(exp_bounce[s]));
      check("bounce_tick", 32'(TICK), 32'h1);
    end

    // Binary count wraps all-ones to zero
    do_reset();
    load_and_run(8'd0, 2'b11);
    for (int s = 0; s <= 16; s++) begin
      cyc();
      if (s == 0)  check("cnt_first", 32'(LED), 32'h1);
      if (s == 14) check("cnt_ones", 32'(LED), 32'hF);
      if (s == 15) check("cnt_wrap", 32'(LED), 32'h0);
      if (s == 16) check("cnt_after", 32'(LED), 32'h1);
    end

    // Mode change seen at the next step only
    do_reset();
    load_and_run(8'd0, 2'b00);
    cyc(); check("chg_pre1", 32'(LED), 32'h2);
    cyc(); check("chg_pre2", 32'(LED), 32'h4);
    MODE = 2'b01;
    cyc(); check("chg_entry", 32'(LED), 32'h1);
    cyc(); check("chg_ror", 32'(LED), 32'h8);

    // Reload mid-count, then freeze with EN low
    do_reset();
    load_and_run(8'd9, 2'b00);
    repeat (7) cyc();
    DIV_LD = 1'b1; DIV = 8'd2;
    cyc();
    check("reload_tick", 32'(TICK), 0);
    check("reload_led", 32'(LED), 32'h1);
    DIV_LD = 1'b0;
    cyc(); check("reload_c1", 32'(TICK), 0);
    EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("frz_tick", 32'(TICK), 0);
      check("frz_led", 32'(LED), 32'h1);
    end
    EN = 1'b1;
    cyc(); check("reload_c2", 32'(TICK), 0);
    cyc(); check("reload_step", 32'(TICK), 32'h1);
    check("reload_led2", 32'(LED), 32'h2);

    // Reset mid-bounce on the way down
    do_reset();
    load_and_run(8'd0, 2'b10);
    repeat (5) cyc();
    check("mid_bounce", 32'(LED), 32'h4);
    RST = 1'b1;
    cyc();
    check("rstb_led", 32'(LED), 32'h1);
    check("rstb_tick", 32'(TICK), 0);
    RST = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("rstb_period", 32'(TICK), (k == 6) ? 32'h1 : 32'h0);
    end
    check("rstb_entry", 32'(LED), 32'h1);
    repeat (6) cyc();
    check("rstb_dir_up", 32'(LED), 32'h2);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      RST    = ($urandom_range(0, 199) == 0);
      DIV_LD = ($urandom_range(0, 39) == 0);
      DIV    = DW'($urandom_range(0, 4));
      EN     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) MODE = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
